// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: loads a 64-bit key and emits K1..K16 (encrypt)
// or K16..K1 (decrypt, by rotating C/D right from C0D0) one subkey per handshake.
module des_key_schedule #(
    parameter int ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        decrypt,
    input  logic [64:1] key,
    input  logic        subkey_ready,
    output logic [48:1] subkey,
    output logic        subkey_valid,
    output logic [4:0]  round,
    output logic        busy,
    output logic        done
);
    typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

    localparam logic [4:0] LAST = 5'(ROUNDS);

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // C/D are held MSB-first: DES position n of the 56-bit C||D sits at index 56-n.
    function automatic logic [55:0] pc1(input logic [64:1] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) r[55-i] = k[65-PC1[i]];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2[i]];
        return r;
    endfunction

    // Rounds 1, 2, 9 and 16 shift by one position, all others by two.
    function automatic logic double_shift(input logic [4:0] r);
        return !(r == 5'd1 || r == 5'd2 || r == 5'd9 || r == 5'd16);
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic dbl);
        return dbl ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic dbl);
        return dbl ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    state_t      state_q, state_d;
    logic        mode_q, mode_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic [4:0]  count_q, count_d;
    logic [4:0]  round_q, round_d;
    logic [47:0] subkey_q, subkey_d;
    logic        done_q, done_d;
    logic        advance;

    logic unused_parity;
    assign unused_parity = ^{key[57], key[49], key[41], key[33],
                             key[25], key[17], key[9], key[1]};

    // subkey_valid/subkey_ready: a subkey transfers on every rising edge where
    // both are high; while valid is high and ready low, subkey and round hold.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        c_d      = c_q;
        d_d      = d_q;
        count_d  = count_q;
        round_d  = round_q;
        subkey_d = subkey_q;
        done_d   = 1'b0;
        advance  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    {c_d, d_d} = pc1(key);
                    mode_d     = decrypt;
                    count_d    = 5'd1;
                    state_d    = EMIT;
                    advance    = 1'b1;
                    if (decrypt) begin
                        round_d = LAST;
                    end else begin
                        round_d = 5'd1;
                        c_d     = rotl(c_d, 1'b0);
                        d_d     = rotl(d_d, 1'b0);
                    end
                end
            end
            EMIT: begin
                if (subkey_ready) begin
                    if (count_q == LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        count_d = count_q + 5'd1;
                        advance = 1'b1;
                        if (mode_q) begin
                            round_d = round_q - 5'd1;
                            c_d     = rotr(c_q, double_shift(round_q));
                            d_d     = rotr(d_q, double_shift(round_q));
                        end else begin
                            round_d = round_q + 5'd1;
                            c_d     = rotl(c_q, double_shift(round_d));
                            d_d     = rotl(d_q, double_shift(round_d));
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (advance) subkey_d = pc2({c_d, d_d});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mode_q   <= 1'b0;
            c_q      <= '0;
            d_q      <= '0;
            count_q  <= '0;
            round_q  <= '0;
            subkey_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            c_q      <= c_d;
            d_q      <= d_d;
            count_q  <= count_d;
            round_q  <= round_d;
            subkey_q <= subkey_d;
            done_q   <= done_d;
        end
    end

    assign subkey       = subkey_q;
    assign subkey_valid = (state_q == EMIT);
    assign busy         = (state_q == EMIT);
    assign round        = round_q;
    assign done         = done_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Bench for des_key_schedule: known-answer table, backpressure, control and
// reset sequences, and random keys checked against a table-level DES model.
module tb_des_key_schedule;
    logic        clk = 1'b0;
    logic        rst, start, decrypt, subkey_ready;
    logic [63:0] key;
    logic [47:0] subkey;
    logic        subkey_valid, busy, done;
    logic [4:0]  round;

    int n_checks = 0;
    int n_fail   = 0;

    logic [52:0] exp_q [$];
    logic [47:0] got_sk [16];
    logic [4:0]  got_rnd [16];

    localparam logic [63:0] K0 = 64'h133457799BBCDFF1;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    typedef struct {
        logic [63:0] key;
        logic        dec;
        int          step;
        logic [47:0] sk;
        logic [4:0]  rnd;
    } vec_t;
    vec_t vecs [9];

    des_key_schedule #(.ROUNDS(16)) dut (
        .clk(clk), .rst(rst), .start(start), .decrypt(decrypt), .key(key),
        .subkey_ready(subkey_ready), .subkey(subkey), .subkey_valid(subkey_valid),
        .round(round), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: C_r/D_r are C0/D0 rotated left by the running shift total.
    task automatic model_schedule(input logic [63:0] k, input logic dec);
        bit          cd [1:56];
        logic [47:0] ks [1:16];
        int          t, p, src;
        for (int i = 1; i <= 56; i++) cd[i] = k[64-PC1[i-1]];
        t = 0;
        for (int r = 1; r <= 16; r++) begin
            t += SHIFTS[r-1];
            for (int m = 1; m <= 48; m++) begin
                p = PC2[m-1];
                if (p <= 28) src = ((p - 1 + t) % 28) + 1;
                else         src = 28 + ((p - 29 + t) % 28) + 1;
                ks[r][48-m] = cd[src];
            end
        end
        for (int i = 1; i <= 16; i++) begin
            if (dec) exp_q.push_back({5'(17 - i), ks[17-i]});
            else     exp_q.push_back({5'(i), ks[i]});
        end
    endtask

    task automatic run_sched(input logic [63:0] k, input logic dec, input bit bp,
                             input bit inj, input bit no_wait);
        int          cyc, hs, stall3;
        bit          stalled, injected, r;
        logic [52:0] held, cur, exp;
        if (!no_wait) begin
            @(negedge clk);
            check("done_one_cycle", {63'd0, done}, 64'd0);
        end
        start = 1'b1; decrypt = dec; key = k; subkey_ready = 1'b0;
        @(negedge clk);
        start = 1'b0; key = {$urandom, $urandom}; decrypt = ~dec;
        check("first_valid", {63'd0, subkey_valid}, 64'd1);
        cyc = 0; hs = 0; stall3 = 0; stalled = 0; injected = 0; held = '0;
        while (hs < 16 && cyc < 400) begin
            start = 1'b0;
            cur = {round, subkey};
            if (stalled) check("hold_stable", {11'd0, cur}, {11'd0, held});
            check("no_early_done", {63'd0, done}, 64'd0);
            r = 1'b1;
            if (bp) begin
                if (round == 5'd3 && stall3 < 5) begin
                    r = 1'b0;
                    stall3++;
                end else begin
                    r = ($urandom_range(0, 2) != 0);
                end
            end
            if (inj && !injected && round == 5'd7) begin
                start = 1'b1; key = ~k; decrypt = ~dec; injected = 1'b1;
            end
            subkey_ready = r;
            if (r && subkey_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL sb_underflow: got %h, expected no handshake", cur);
                end else begin
                    exp = exp_q.pop_front();
                    check("sb_subkey", {16'd0, cur[47:0]}, {16'd0, exp[47:0]});
                    check("sb_round", {59'd0, cur[52:48]}, {59'd0, exp[52:48]});
                end
                got_sk[hs] = subkey; got_rnd[hs] = round;
                hs++;
            end
            stalled = subkey_valid && !r;
            held = cur;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0; subkey_ready = 1'b0;
        if (hs < 16) begin
            n_checks++; n_fail++;
            $display("FAIL timeout: got %0d handshakes, expected 16", hs);
            exp_q.delete();
        end
        check("done_pulse", {63'd0, done}, 64'd1);
        check("busy_end", {63'd0, busy}, 64'd0);
        check("valid_end", {63'd0, subkey_valid}, 64'd0);
        if (!bp) check("latency", 64'(cyc), 64'd16);
        if (bp)  check("stall_r3", 64'(stall3), 64'd5);
    endtask

    initial begin
        int cyc;
        logic [63:0] rk;
        logic        rd;
        rst = 1'b1; start = 1'b0; decrypt = 1'b0; key = '0; subkey_ready = 1'b0;
        vecs[0] = '{K0, 1'b0, 1,  48'h1B02EFFC7072, 5'd1};
        vecs[1] = '{K0, 1'b0, 2,  48'h79AED9DBC9E5, 5'd2};
        vecs[2] = '{K0, 1'b0, 16, 48'hCB3D8B0E17F5, 5'd16};
        vecs[3] = '{K0, 1'b1, 1,  48'hCB3D8B0E17F5, 5'd16};
        vecs[4] = '{K0, 1'b1, 16, 48'h1B02EFFC7072, 5'd1};
        vecs[5] = '{64'h0101010101010101, 1'b0, 1,  48'h000000000000, 5'd1};
        vecs[6] = '{64'h0101010101010101, 1'b0, 16, 48'h000000000000, 5'd16};
        vecs[7] = '{64'hFEFEFEFEFEFEFEFE, 1'b1, 1,  48'hFFFFFFFFFFFF, 5'd16};
        vecs[8] = '{64'hFEFEFEFEFEFEFEFE, 1'b0, 9,  48'hFFFFFFFFFFFF, 5'd9};

        repeat (3) @(negedge clk);
        check("reset_subkey", {16'd0, subkey}, 64'd0);
        check("reset_valid", {63'd0, subkey_valid}, 64'd0);
        check("reset_round", {59'd0, round}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        rst = 1'b0;

        for (int v = 0; v < 9; v++) begin
            model_schedule(vecs[v].key, vecs[v].dec);
            run_sched(vecs[v].key, vecs[v].dec, 1'b0, 1'b0, 1'b0);
            check($sformatf("vec%0d_subkey", v), {16'd0, got_sk[vecs[v].step-1]}, {16'd0, vecs[v].sk});
            check($sformatf("vec%0d_round", v), {59'd0, got_rnd[vecs[v].step-1]}, {59'd0, vecs[v].rnd});
        end

        // Backpressure, then a start injected mid-schedule that must be ignored.
        model_schedule(K0, 1'b0);
        run_sched(K0, 1'b0, 1'b1, 1'b0, 1'b0);
        model_schedule(K0, 1'b0);
        run_sched(K0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Start in the done cycle chains straight into a new schedule.
        model_schedule(K0, 1'b1);
        run_sched(K0, 1'b1, 1'b0, 1'b0, 1'b0);
        model_schedule(64'h0E329232EA6D0D73, 1'b0);
        run_sched(64'h0E329232EA6D0D73, 1'b0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a schedule.
        @(negedge clk);
        start = 1'b1; decrypt = 1'b0; key = K0; subkey_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (round != 5'd9 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("reach_round9", {59'd0, round}, 64'd9);
        rst = 1'b1;
        #1;
        check("midrst_subkey", {16'd0, subkey}, 64'd0);
        check("midrst_valid", {63'd0, subkey_valid}, 64'd0);
        check("midrst_round", {59'd0, round}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        subkey_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_schedule(K0, 1'b0);
        run_sched(K0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 20; n++) begin
            rk = {$urandom, $urandom};
            rd = 1'($urandom_range(0, 1));
            model_schedule(rk, rd);
            run_sched(rk, rd, 1'b1, 1'b0, 1'b0);
        end

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
